event_bcd_counter: RTL and testbench

//  Counts debounced rising edges of the raw push-button/sensor input and presents

---
 rtl/event_bcd_counter_pkg.sv | 12 +
 rtl/bcd_digit.sv | 29 ++
 rtl/event_bcd_counter.sv | 109 ++++++++++
 tb/tb_event_bcd_counter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_bcd_counter_pkg.sv
// Shared widths and helpers for the debounced event counter and its BCD decades.
package event_bcd_counter_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  function automatic logic is_max(input logic [BCD_W-1:0] d);
    return d == BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade (0..9) with carry-in/carry-out; chained to build the live count.
module bcd_digit
  import event_bcd_counter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             cin,
  output logic [BCD_W-1:0] q,
  output logic             cout
);

  logic [BCD_W-1:0] r_q;

  // Out-of-range values (10..15) fall back to 0 on the next increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (cin) begin
      r_q <= (r_q >= BCD_MAX) ? '0 : r_q + 1'b1;
    end
  end

  assign q    = r_q;
  assign cout = cin & is_max(r_q);

endmodule

// File: rtl/event_bcd_counter.sv
// Debounced rising-edge counter driving four frozen-on-refresh BCD display digits.
module event_bcd_counter
  import event_bcd_counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 16,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inp,
  input  logic             clr,
  input  logic             freeze,
  output logic [BCD_W-1:0] count0,
  output logic [BCD_W-1:0] count1,
  output logic [BCD_W-1:0] count2,
  output logic [BCD_W-1:0] count3,
  output logic             ovf,
  output logic             evt
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);

  logic             r_s1, r_s2, r_db, r_db_d, r_evt, r_ovf;
  logic [CNT_W-1:0] r_deb_cnt;
  logic [BCD_W-1:0] r_disp [NUM_DIGITS];
  logic [BCD_W-1:0] w_live [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_cin, w_cout;
  logic             w_inc, w_all9, w_cin0, w_ovf_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_db      <= 1'b0;
      r_db_d    <= 1'b0;
      r_deb_cnt <= '0;
      r_evt     <= 1'b0;
    end else begin
      r_s1   <= inp;
      r_s2   <= r_s1;
      r_db_d <= r_db;
      r_evt  <= w_inc;
      if (r_s2 == r_db) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_LAST) begin
        r_db      <= r_s2;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  assign w_inc = r_db & ~r_db_d;

  always_comb begin
    w_all9 = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_all9 = w_all9 & is_max(w_live[i]);
    end
  end

  // Saturation blocks the chain at its source; clr wins over a coincident event.
  assign w_cin0 = w_inc & ~clr & ~(SATURATE & w_all9);
  assign w_ovf_set = SATURATE ? (w_inc & ~clr & w_all9) : w_cout[NUM_DIGITS-1];

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    if (gi == 0) begin : g_first
      assign w_cin[gi] = w_cin0;
    end else begin : g_rest
      assign w_cin[gi] = w_cout[gi-1];
    end
    bcd_digit u_digit (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .cin  (w_cin[gi]),
      .q    (w_live[gi]),
      .cout (w_cout[gi])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (clr) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_disp[i] <= '0;
    end else if (!freeze) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_disp[i] <= w_live[i];
    end
  end

  assign count0 = r_disp[0];
  assign count1 = r_disp[1];
  assign count2 = r_disp[2];
  assign count3 = r_disp[3];
  assign ovf    = r_ovf;
  assign evt    = r_evt;

endmodule

// File: tb/tb_event_bcd_counter.sv
// Randomized bench: a wrapping and a saturating instance share stimulus against an integer model.
module tb_event_bcd_counter;

  localparam int unsigned D = 2;

  logic clk = 1'b0;
  logic rst, inp, clr, freeze;
  logic [3:0] a0, a1, a2, a3, b0, b1, b2, b3;
  logic ovf_a, evt_a, ovf_b, evt_b;

  int checks = 0;
  int errors = 0;
  int model_a, model_b;
  bit mov_a, mov_b;
  int evt_seen_a, evt_seen_b;

  always #5 clk = ~clk;

  event_bcd_counter #(.DEBOUNCE(D), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .inp(inp), .clr(clr), .freeze(freeze),
    .count0(a0), .count1(a1), .count2(a2), .count3(a3), .ovf(ovf_a), .evt(evt_a)
  );

  event_bcd_counter #(.DEBOUNCE(D), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .inp(inp), .clr(clr), .freeze(freeze),
    .count0(b0), .count1(b1), .count2(b2), .count3(b3), .ovf(ovf_b), .evt(evt_b)
  );

  function automatic logic [15:0] bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] disp_a();
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [15:0] disp_b();
    return {b3, b2, b1, b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (evt_a === 1'b1) evt_seen_a++;
    if (evt_b === 1'b1) evt_seen_b++;
  endtask

  task automatic settle();
    inp = 1'b0;
    repeat (D + 5) tick();
  endtask

  task automatic clean_event(input int h, input int l);
    inp = 1'b1;
    repeat (h) tick();
    inp = 1'b0;
    repeat (l) tick();
    if (model_a == 9999) begin model_a = 0; mov_a = 1'b1; end
    else model_a++;
    if (model_b == 9999) mov_b = 1'b1;
    else model_b++;
  endtask

  task automatic glitch();
    inp = 1'b1;
    repeat ($urandom_range(1, D - 1)) tick();
    inp = 1'b0;
    repeat (D + 1) tick();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    model_a = 0; model_b = 0; mov_a = 1'b0; mov_b = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; inp = 1'b0; clr = 1'b0; freeze = 1'b0;
    repeat (3) tick();
    checks++;
    if ({disp_a(), ovf_a, evt_a} !== 18'd0) begin
      errors++; $display("FAIL reset_wrap got %h exp 0", {disp_a(), ovf_a, evt_a});
    end
    checks++;
    if ({disp_b(), ovf_b, evt_b} !== 18'd0) begin
      errors++; $display("FAIL reset_sat got %h exp 0", {disp_b(), ovf_b, evt_b});
    end
    rst = 1'b0;
    tick();
    model_a = 0; model_b = 0; mov_a = 1'b0; mov_b = 1'b0;
  endtask

  // inp rises ahead of edge n=1; evt expected after edge D+3, display after edge D+4.
  task automatic test_latency();
    evt_seen_a = 0;
    inp = 1'b1;
    for (int n = 1; n <= int'(D) + 5; n++) begin
      tick();
      checks++;
      if (evt_a !== (n == int'(D) + 3)) begin
        errors++; $display("FAIL latency_evt n=%0d got %b exp %b", n, evt_a, n == int'(D) + 3);
      end
      checks++;
      if (a0 !== ((n >= int'(D) + 4) ? 4'd1 : 4'd0)) begin
        errors++; $display("FAIL latency_count0 n=%0d got %0d", n, a0);
      end
    end
    settle();
    model_a = 1; model_b = 1;
    checks++;
    if (evt_seen_a != 1) begin
      errors++; $display("FAIL latency_evt_once got %0d exp 1", evt_seen_a);
    end
  endtask

  task automatic test_glitch();
    evt_seen_a = 0;
    repeat (10) glitch();
    settle();
    checks++;
    if (disp_a() !== bcd(model_a)) begin
      errors++; $display("FAIL glitch_count got %h exp %h", disp_a(), bcd(model_a));
    end
    checks++;
    if (evt_seen_a != 0) begin
      errors++; $display("FAIL glitch_evt got %0d exp 0", evt_seen_a);
    end
  endtask

  task automatic test_random();
    int snap, ev;
    bit frz;
    for (int r = 0; r < 20; r++) begin
      if ($urandom_range(0, 3) == 0) do_clr();
      frz = 1'($urandom_range(0, 1));
      freeze = frz;
      snap = model_a;
      ev = 0;
      evt_seen_a = 0;
      repeat ($urandom_range(1, 6)) begin
        if ($urandom_range(0, 2) == 0) glitch();
        else begin
          clean_event($urandom_range(D, D + 3), $urandom_range(D, D + 3));
          ev++;
        end
      end
      settle();
      checks++;
      if (disp_a() !== bcd(frz ? snap : model_a)) begin
        errors++;
        $display("FAIL random_held r=%0d got %h exp %h", r, disp_a(), bcd(frz ? snap : model_a));
      end
      checks++;
      if (evt_seen_a != ev) begin
        errors++; $display("FAIL random_evt r=%0d got %0d exp %0d", r, evt_seen_a, ev);
      end
      checks++;
      if (ovf_a !== mov_a) begin
        errors++; $display("FAIL random_ovf r=%0d got %b exp %b", r, ovf_a, mov_a);
      end
      freeze = 1'b0;
      tick();
      checks++;
      if ({disp_a(), disp_b()} !== {bcd(model_a), bcd(model_b)}) begin
        errors++;
        $display("FAIL random_live r=%0d got %h/%h exp %h/%h", r, disp_a(), disp_b(),
                 bcd(model_a), bcd(model_b));
      end
    end
  endtask

  task automatic test_freeze();
    do_clr();
    repeat (129) clean_event(D, D);
    settle();
    freeze = 1'b1;
    repeat (3) clean_event(D + 1, D);
    settle();
    checks++;
    if (disp_a() !== 16'h0129) begin
      errors++; $display("FAIL freeze_hold got %h exp 0129", disp_a());
    end
    freeze = 1'b0;
    tick();
    checks++;
    if (disp_a() !== 16'h0132 || model_a != 132) begin
      errors++; $display("FAIL freeze_release got %h exp 0132", disp_a());
    end
  endtask

  task automatic test_clr_collision();
    do_clr();
    repeat (42) clean_event(D, D + 1);
    settle();
    checks++;
    if (disp_a() !== 16'h0042) begin
      errors++; $display("FAIL clr_pre got %h exp 0042", disp_a());
    end
    inp = 1'b1;
    repeat (D + 2) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (evt_a !== 1'b1) begin
      errors++; $display("FAIL clr_evt got %b exp 1", evt_a);
    end
    tick();
    checks++;
    if ({disp_a(), ovf_a} !== 17'd0) begin
      errors++; $display("FAIL clr_count got %h ovf %b exp 0000 0", disp_a(), ovf_a);
    end
    settle();
    model_a = 0; model_b = 0; mov_a = 1'b0; mov_b = 1'b0;
    clean_event(D, D);
    settle();
    checks++;
    if (disp_a() !== 16'h0001) begin
      errors++; $display("FAIL clr_next got %h exp 0001", disp_a());
    end
  endtask

  task automatic test_overflow();
    do_clr();
    repeat (9999) clean_event(D, D);
    settle();
    checks++;
    if ({disp_a(), ovf_a, disp_b(), ovf_b} !== {16'h9999, 1'b0, 16'h9999, 1'b0}) begin
      errors++; $display("FAIL ovf_pre got %h %b %h %b", disp_a(), ovf_a, disp_b(), ovf_b);
    end
    repeat (2) begin
      clean_event(D, D);
      settle();
      checks++;
      if ({disp_a(), ovf_a} !== {bcd(model_a), mov_a}) begin
        errors++; $display("FAIL ovf_wrap got %h %b exp %h %b", disp_a(), ovf_a, bcd(model_a), mov_a);
      end
      checks++;
      if ({disp_b(), ovf_b} !== {bcd(model_b), mov_b}) begin
        errors++; $display("FAIL ovf_sat got %h %b exp %h %b", disp_b(), ovf_b, bcd(model_b), mov_b);
      end
    end
  endtask

  task automatic test_reset_mid();
    freeze = 1'b1;
    inp = 1'b1;
    repeat (D + 1) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({disp_a(), ovf_a, evt_a, disp_b(), ovf_b, evt_b} !== 36'd0) begin
      errors++; $display("FAIL reset_mid got %h %h", {disp_a(), ovf_a}, {disp_b(), ovf_b});
    end
    repeat (2) tick();
    rst = 1'b0;
    inp = 1'b0;
    freeze = 1'b0;
    evt_seen_a = 0;
    model_a = 0; model_b = 0; mov_a = 1'b0; mov_b = 1'b0;
    repeat (D + 5) tick();
    checks++;
    if (disp_a() !== 16'h0000 || evt_seen_a != 0) begin
      errors++; $display("FAIL reset_quiet got %h evts %0d exp 0000 0", disp_a(), evt_seen_a);
    end
    clean_event(D + 2, D);
    settle();
    checks++;
    if ({disp_a(), disp_b()} !== {bcd(model_a), bcd(model_b)}) begin
      errors++; $display("FAIL reset_next got %h/%h exp 0001", disp_a(), disp_b());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_random();
    test_freeze();
    test_clr_collision();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
